// File: rtl/srff_bank_arbiter.sv
// srff_bank_arbiter: round-robin arbiter sharing one bank of SR storage bits
//   i.e. NREQ requesters each issue set/reset commands to a shared NBITS bank.
// Ports:
//   clk   - clock, all state updates on posedge
//   rst_n - asynchronous active-low reset
//   req   - per-requester level request, held until granted
//   s, r  - per-requester set / reset command (set wins when both high)
//   addr  - per-requester bit index, requester i at addr[i*AW +: AW]
//   gnt   - one-hot grant, pulses for the cycle the command is applied
//   q     - bank state, qbar its complement
//   busy  - high while a command is being applied
module srff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      s,
  input  logic [NREQ-1:0]      r,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     q,
  output logic [NBITS-1:0]     qbar,
  output logic                 busy
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {IDLE, APPLY} state_t;
  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_win;
  logic             r_s_l;
  logic             r_r_l;
  logic [AW-1:0]    r_addr_l;
  logic [NBITS-1:0] r_q;
  logic [NREQ-1:0]  r_gnt;
  logic             r_busy;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_idx;
  // scan from farthest offset down so the nearest asserted req at/after r_ptr wins
  always_comb begin
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int i = NREQ-1; i >= 0; i--) begin
      w_idx = r_ptr + PW'(i);
      if (req[w_idx]) w_win = w_idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_s_l    <= 1'b0;
      r_r_l    <= 1'b0;
      r_addr_l <= '0;
      r_q      <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (|req) begin
        r_state  <= APPLY;
        r_win    <= w_win;
        r_s_l    <= s[w_win];
        r_r_l    <= r[w_win];
        r_addr_l <= addr[int'(w_win)*AW +: AW];
        r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
        r_busy   <= 1'b1;
      end
    end else begin
      // set has priority; neither command leaves the bit held
      if (r_s_l | r_r_l) r_q[r_addr_l] <= r_s_l;
      r_ptr   <= r_win + PW'(1);
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_state <= IDLE;
    end
  end
  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign q    = r_q;
  assign qbar = ~r_q;
endmodule

// File: tb/tb_srff_bank_arbiter.sv
// tb_srff_bank_arbiter: directed self-checking bench for srff_bank_arbiter
module tb_srff_bank_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  s = '0;
  logic [3:0]  r = '0;
  logic [11:0] addr = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic        busy;
  int          n_tests = 0;
  int          n_fail = 0;
  srff_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .s(s), .r(r), .addr(addr),
    .gnt(gnt), .q(q), .qbar(qbar), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk_all(input string tag, input logic [3:0] eg, input logic eb, input logic [7:0] eq);
    chk({tag, ".gnt"}, {4'h0, gnt}, {4'h0, eg});
    chk({tag, ".busy"}, {7'h0, busy}, {7'h0, eb});
    chk({tag, ".q"}, q, eq);
    chk({tag, ".qbar"}, qbar, ~eq);
  endtask
  task automatic cmd(input int i, input logic si, input logic ri, input logic [2:0] a);
    req = 4'b0001 << i;
    s = {3'b0, si} << i;
    r = {3'b0, ri} << i;
    addr[i*3 +: 3] = a;
  endtask
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 chk_all("mid_reset", 4'b0000, 1'b0, 8'h00);
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 chk_all("reset_t0", 4'b0000, 1'b0, 8'h00);
    req = 4'b1111;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("rr%0d", k), (k % 2 == 1) ? (4'b0001 << ((k - 1) / 2)) : 4'b0000,
              k % 2 == 1, 8'h00);
    end
    req = '0;
    step();
    chk_all("rr_idle", 4'b0000, 1'b0, 8'h00);
    cmd(0, 1'b1, 1'b0, 3'd5);
    step();
    chk_all("set5_gnt", 4'b0001, 1'b1, 8'h00);
    req = '0;
    step();
    chk_all("set5_q", 4'b0000, 1'b0, 8'h20);
    step();
    chk_all("set5_hold", 4'b0000, 1'b0, 8'h20);
    mid_reset();
    cmd(1, 1'b1, 1'b1, 3'd2);
    step();
    chk_all("sr_gnt", 4'b0010, 1'b1, 8'h00);
    req = '0;
    step();
    chk_all("sr_q", 4'b0000, 1'b0, 8'h04);
    cmd(1, 1'b0, 1'b1, 3'd2);
    step();
    req = '0;
    step();
    chk_all("r_q", 4'b0000, 1'b0, 8'h00);
    cmd(1, 1'b1, 1'b0, 3'd2);
    step();
    req = '0;
    step();
    chk("s_q", q, 8'h04);
    cmd(1, 1'b0, 1'b0, 3'd2);
    step();
    chk("hold_gnt", {4'h0, gnt}, 8'h02);
    req = '0;
    step();
    chk("hold_q", q, 8'h04);
    mid_reset();
    cmd(1, 1'b0, 1'b0, 3'd0);
    step();
    req = '0;
    step();
    cmd(3, 1'b1, 1'b0, 3'd7);
    step();
    chk_all("abort_gnt", 4'b1000, 1'b1, 8'h00);
    rst_n = 1'b0;
    req = '0;
    #1 chk_all("abort_rst", 4'b0000, 1'b0, 8'h00);
    step();
    chk_all("abort_hold", 4'b0000, 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    chk_all("abort_idle", 4'b0000, 1'b0, 8'h00);
    req = 4'b1111;
    s = '0;
    r = '0;
    step();
    chk_all("abort_next", 4'b0001, 1'b1, 8'h00);
    req = '0;
    step();
    cmd(2, 1'b1, 1'b0, 3'd1);
    step();
    chk_all("chg_gnt", 4'b0100, 1'b1, 8'h00);
    addr[6 +: 3] = 3'd6;
    s = '0;
    r = 4'b0100;
    req = '0;
    step();
    chk_all("chg_q", 4'b0000, 1'b0, 8'h02);
    step();
    chk_all("chg_idle", 4'b0000, 1'b0, 8'h02);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
